// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops, plus N-cycle
// shift-add multiply and restoring divide sharing one accumulator pair.
module alu_multicycle #(
    parameter int N = 8
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iStart,
    input  logic [N-1:0] iX,
    input  logic [N-1:0] iY,
    input  logic [3:0]   iALUop,
    output logic         oBusy,
    output logic         oDone,
    output logic [N-1:0] oF,
    output logic [3:0]   oFlag
);

    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] CNT_LAST = SW'(N - 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_SLTU  = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REMU  = 4'd14;

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   x_q, x_d;
    logic [N-1:0]   y_q, y_d;
    logic [3:0]     op_q, op_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   acc_hi_q, acc_hi_d;
    logic [N-1:0]   acc_lo_q, acc_lo_d;
    logic [N-1:0]   f_q, f_d;
    logic [3:0]     flag_q, flag_d;

    logic [N+1:0]   single_res;
    logic [N:0]     mul_sum;
    logic [N-1:0]   mul_hi_nx, mul_lo_nx;
    logic [N:0]     div_sh, div_diff;
    logic           div_ok;
    logic [N-1:0]   div_hi_nx, div_lo_nx;
    logic [N-1:0]   iter_f;
    logic           iter_cout;
    logic           op_is_div;

    // Returns {overflow, carryOut, F} for every op that completes in one cycle.
    function automatic logic [N+1:0] alu_single(input logic [N-1:0] x,
                                                input logic [N-1:0] y,
                                                input logic [3:0]   op);
        logic [N:0]           sum;
        logic [SW-1:0]        sh;
        logic signed [N-1:0]  xs;
        logic signed [N-1:0]  ys;
        logic [N-1:0]         f;
        logic                 ovf;
        logic                 cout;
        sum  = '0;
        sh   = y[SW-1:0];
        xs   = x;
        ys   = y;
        f    = '0;
        ovf  = 1'b0;
        cout = 1'b0;
        case (op)
            OP_ADD: begin
                sum  = {1'b0, x} + {1'b0, y};
                f    = sum[N-1:0];
                cout = sum[N];
                ovf  = (x[N-1] == y[N-1]) && (f[N-1] != x[N-1]);
            end
            OP_SUB: begin
                sum  = {1'b0, x} + {1'b0, ~y} + {{N{1'b0}}, 1'b1};
                f    = sum[N-1:0];
                cout = sum[N];
                ovf  = (x[N-1] != y[N-1]) && (f[N-1] != x[N-1]);
            end
            OP_AND:  f = x & y;
            OP_OR:   f = x | y;
            OP_XOR:  f = x ^ y;
            OP_NOR:  f = ~(x | y);
            OP_SLL:  f = x << sh;
            OP_SRL:  f = x >> sh;
            OP_SRA:  f = xs >>> sh;
            OP_SLT:  f = (xs < ys) ? {{(N-1){1'b0}}, 1'b1} : '0;
            OP_SLTU: f = (x < y)   ? {{(N-1){1'b0}}, 1'b1} : '0;
            default: f = '0;
        endcase
        return {ovf, cout, f};
    endfunction

    function automatic logic [3:0] make_flags(input logic [N-1:0] f,
                                              input logic ovf,
                                              input logic cout);
        return {f[N-1], (f == '0), ovf, cout};
    endfunction

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        f_d      = f_q;
        flag_d   = flag_q;

        single_res = alu_single(iX, iY, iALUop);
        op_is_div  = (op_q == OP_DIVU) || (op_q == OP_REMU);

        // Shift-add multiply step: {hi, lo} holds partial product and multiplier.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, x_q} : '0);
        mul_hi_nx = mul_sum[N:1];
        mul_lo_nx = {mul_sum[0], acc_lo_q[N-1:1]};

        // Restoring divide step: hi is the remainder, lo shifts dividend out / quotient in.
        div_sh    = {acc_hi_q, acc_lo_q[N-1]};
        div_diff  = div_sh - {1'b0, y_q};
        div_ok    = ~div_diff[N];
        div_hi_nx = div_ok ? div_diff[N-1:0] : div_sh[N-1:0];
        div_lo_nx = {acc_lo_q[N-2:0], div_ok};

        case (op_q)
            OP_MUL:   iter_f = mul_lo_nx;
            OP_MULHU: iter_f = mul_hi_nx;
            OP_DIVU:  iter_f = div_lo_nx;
            default:  iter_f = div_hi_nx;
        endcase
        iter_cout = op_is_div ? (y_q == '0) : (mul_hi_nx != '0);

        // The accepting IDLE cycle counts as busy: that is where single-cycle ops compute.
        oBusy = ~iRst && ((state_q == ITER) || ((state_q == IDLE) && iStart));
        oDone = (state_q == FIN);

        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (iStart) begin
                    x_d   = iX;
                    y_d   = iY;
                    op_d  = iALUop;
                    cnt_d = '0;
                    if (iALUop >= OP_MUL && iALUop <= OP_REMU) begin
                        state_d  = ITER;
                        acc_hi_d = '0;
                        acc_lo_d = (iALUop >= OP_DIVU) ? iX : iY;
                    end else begin
                        state_d = FIN;
                        f_d     = single_res[N-1:0];
                        flag_d  = make_flags(single_res[N-1:0], single_res[N+1], single_res[N]);
                    end
                end
            end
            ITER: begin
                cnt_d    = cnt_q + 1'b1;
                acc_hi_d = op_is_div ? div_hi_nx : mul_hi_nx;
                acc_lo_d = op_is_div ? div_lo_nx : mul_lo_nx;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIN;
                    f_d     = iter_f;
                    flag_d  = make_flags(iter_f, 1'b0, iter_cout);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            f_q      <= '0;
            flag_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            f_q      <= f_d;
            flag_q   <= flag_d;
        end
    end

    assign oF    = f_q;
    assign oFlag = flag_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: one N=4 and one N=8 instance on a shared clock.
module tb_alu_multicycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, s4, busy4, done4;
    logic [3:0] x4, y4, op4, f4, flag4;
    logic       rst8, s8, busy8, done8;
    logic [7:0] x8, y8, f8;
    logic [3:0] op8, flag8;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.N(4)) dut4 (
        .iClk(clk), .iRst(rst4), .iStart(s4), .iX(x4), .iY(y4), .iALUop(op4),
        .oBusy(busy4), .oDone(done4), .oF(f4), .oFlag(flag4)
    );

    alu_multicycle #(.N(8)) dut8 (
        .iClk(clk), .iRst(rst8), .iStart(s8), .iX(x8), .iY(y8), .iALUop(op8),
        .oBusy(busy8), .oDone(done8), .oF(f8), .oFlag(flag8)
    );

    // {op, x, y, expected F, expected flags} for single-cycle ops at N=4
    logic [19:0] single_vec [17] = '{
        {4'd0,  4'h7, 4'h1, 4'h8, 4'b1010},
        {4'd1,  4'h3, 4'h3, 4'h0, 4'b0101},
        {4'd0,  4'hF, 4'h1, 4'h0, 4'b0101},
        {4'd0,  4'h4, 4'h4, 4'h8, 4'b1010},
        {4'd1,  4'h3, 4'h5, 4'hE, 4'b1000},
        {4'd1,  4'h8, 4'h1, 4'h7, 4'b0011},
        {4'd2,  4'hC, 4'hA, 4'h8, 4'b1000},
        {4'd3,  4'h4, 4'h1, 4'h5, 4'b0000},
        {4'd4,  4'h5, 4'h3, 4'h6, 4'b0000},
        {4'd5,  4'h5, 4'h3, 4'h8, 4'b1000},
        {4'd6,  4'h3, 4'h2, 4'hC, 4'b1000},
        {4'd7,  4'h8, 4'h5, 4'h4, 4'b0000},
        {4'd8,  4'h8, 4'h1, 4'hC, 4'b1000},
        {4'd8,  4'h9, 4'h0, 4'h9, 4'b1000},
        {4'd9,  4'hF, 4'h1, 4'h1, 4'b0000},
        {4'd10, 4'hF, 4'h1, 4'h0, 4'b0100},
        {4'd15, 4'hF, 4'hF, 4'h0, 4'b0100}
    };

    task automatic start4(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y,
                          output logic b0);
        op4 = op; x4 = x; y4 = y; s4 = 1'b1;
        #1 b0 = busy4;
        @(negedge clk);
        s4 = 1'b0;
    endtask

    task automatic start8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                          output logic b0);
        op8 = op; x8 = x; y8 = y; s8 = 1'b1;
        #1 b0 = busy8;
        @(negedge clk);
        s8 = 1'b0;
    endtask

    task automatic wait4(input int k0, output int lat, output int nbusy);
        lat = -1; nbusy = 0;
        for (int k = k0; k < k0 + 40; k++) begin
            #1;
            if (done4 === 1'b1) begin lat = k; break; end
            if (busy4 === 1'b1) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic wait8(input int k0, output int lat, output int nbusy);
        lat = -1; nbusy = 0;
        for (int k = k0; k < k0 + 40; k++) begin
            #1;
            if (done8 === 1'b1) begin lat = k; break; end
            if (busy8 === 1'b1) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst8 = 1'b1; s4 = 1'b0; s8 = 1'b0;
        x4 = '0; y4 = '0; op4 = '0; x8 = '0; y8 = '0; op8 = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy4, done4, f4, flag4} !== 10'b0) begin
            errors++;
            $display("FAIL reset4: busy=%b done=%b f=%h flag=%b, expected all zero", busy4, done4, f4, flag4);
        end
        checks++;
        if ({busy8, done8, f8, flag8} !== 14'b0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b f=%h flag=%b, expected all zero", busy8, done8, f8, flag8);
        end
        @(negedge clk);
    endtask

    // First row is issued on the very edge after reset deasserts.
    task automatic test_single_ops();
        logic [3:0] op, x, y, ef, eflag;
        logic       b0;
        int         lat, nb;
        rst4 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            {op, x, y, ef, eflag} = single_vec[i];
            start4(op, x, y, b0);
            wait4(1, lat, nb);
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL single_lat[%0d] op=%0d: latency=%0d, expected 1", i, op, lat);
            end
            checks++;
            if (f4 !== ef || flag4 !== eflag) begin
                errors++;
                $display("FAIL single[%0d] op=%0d x=%h y=%h: f=%h flag=%b, expected f=%h flag=%b",
                         i, op, x, y, f4, flag4, ef, eflag);
            end
            @(negedge clk);
            #1;
            checks++;
            if (done4 !== 1'b0 || f4 !== ef) begin
                errors++;
                $display("FAIL single_hold[%0d]: done=%b f=%h, expected done=0 f=%h", i, done4, f4, ef);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mul();
        logic [3:0] mop [4]  = '{4'd11, 4'd12, 4'd11, 4'd12};
        logic [3:0] mx  [4]  = '{4'h6,  4'h6,  4'hF,  4'hF};
        logic [3:0] my  [4]  = '{4'h5,  4'h5,  4'hF,  4'hF};
        logic [3:0] mf  [4]  = '{4'hE,  4'h1,  4'h1,  4'hE};
        logic [3:0] mfl [4]  = '{4'b1001, 4'b0001, 4'b0001, 4'b1001};
        logic b0;
        int   lat, nb;
        for (int i = 0; i < 4; i++) begin
            start4(mop[i], mx[i], my[i], b0);
            wait4(1, lat, nb);
            checks++;
            if (lat !== 5 || (b0 ? 1 : 0) + nb !== 5) begin
                errors++;
                $display("FAIL mul_timing[%0d]: latency=%0d busy_cycles=%0d, expected 5 and 5",
                         i, lat, (b0 ? 1 : 0) + nb);
            end
            checks++;
            if (f4 !== mf[i] || flag4 !== mfl[i]) begin
                errors++;
                $display("FAIL mul[%0d] op=%0d: f=%h flag=%b, expected f=%h flag=%b",
                         i, mop[i], f4, flag4, mf[i], mfl[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div();
        logic b0;
        int   lat, nb;
        rst8 = 1'b0;
        start8(4'd13, 8'd100, 8'd7, b0);
        wait8(1, lat, nb);
        checks++;
        if (lat !== 9 || f8 !== 8'd14 || flag8 !== 4'b0000) begin
            errors++;
            $display("FAIL divu8: latency=%0d f=%0d flag=%b, expected 9 14 0000", lat, f8, flag8);
        end
        @(negedge clk);
        start8(4'd14, 8'd100, 8'd7, b0);
        wait8(1, lat, nb);
        checks++;
        if (lat !== 9 || f8 !== 8'd2 || flag8 !== 4'b0000) begin
            errors++;
            $display("FAIL remu8: latency=%0d f=%0d flag=%b, expected 9 2 0000", lat, f8, flag8);
        end
        @(negedge clk);
        start4(4'd13, 4'd9, 4'd0, b0);
        wait4(1, lat, nb);
        checks++;
        if (lat !== 5 || f4 !== 4'hF || flag4 !== 4'b1001) begin
            errors++;
            $display("FAIL divu4_y0: latency=%0d f=%h flag=%b, expected 5 f 1001", lat, f4, flag4);
        end
        @(negedge clk);
        start4(4'd14, 4'd9, 4'd0, b0);
        wait4(1, lat, nb);
        checks++;
        if (lat !== 5 || f4 !== 4'h9 || flag4 !== 4'b1001) begin
            errors++;
            $display("FAIL remu4_y0: latency=%0d f=%h flag=%b, expected 5 9 1001", lat, f4, flag4);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic b0;
        int   lat, nb;
        start4(4'd11, 4'h6, 4'h5, b0);
        @(negedge clk);
        op4 = 4'd0; x4 = 4'h1; y4 = 4'h1; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0; x4 = 4'h3; y4 = 4'h2;
        wait4(3, lat, nb);
        checks++;
        if (lat !== 5 || f4 !== 4'hE || flag4 !== 4'b1001) begin
            errors++;
            $display("FAIL b2b_mul: latency=%0d f=%h flag=%b, expected 5 e 1001", lat, f4, flag4);
        end
        op4 = 4'd0; x4 = 4'h2; y4 = 4'h3; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        #1;
        checks++;
        if (done4 !== 1'b1 || f4 !== 4'h5 || flag4 !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_add: done=%b f=%h flag=%b, expected 1 5 0000", done4, f4, flag4);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done4 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_single_pulse: done=%b, expected 0", done4);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic b0;
        int   seen;
        start8(4'd13, 8'd100, 8'd7, b0);
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || f8 !== 8'd0 || flag8 !== 4'd0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b f=%h flag=%b, expected 0 0 00 0000",
                     busy8, done8, f8, flag8);
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (done8 === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d, expected 0", seen);
        end
        op8 = 4'd0; x8 = 8'd1; y8 = 8'd1; s8 = 1'b1; rst8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0; rst8 = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (done8 === 1'b1 || busy8 === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_over_start: busy/done cycles=%0d, expected 0", seen);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_ops();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
